// File: rtl/uart_mmio_ctrl_pkg.sv
// MMIO map and status layout for the CPU <-> UART controller.
// Shared by address decode, the controller and BIOS-side tests.
package uart_mmio_ctrl_pkg;

    localparam logic [31:0] MMIO_UART_CTRL = 32'h8000_0000;
    localparam logic [31:0] MMIO_UART_RX   = 32'h8000_0004;
    localparam logic [31:0] MMIO_UART_TX   = 32'h8000_0008;
    localparam logic [31:0] MMIO_CYCLE_CNT = 32'h8000_0010;
    localparam logic [31:0] MMIO_INST_CNT  = 32'h8000_0014;
    localparam logic [31:0] MMIO_CNT_RST   = 32'h8000_0018;

    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_TX_OVERFLOW  = 2;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_UART_CTRL,
        REG_UART_RX,
        REG_UART_TX,
        REG_CYCLE_CNT,
        REG_INST_CNT,
        REG_CNT_RST
    } mmio_reg_e;

    // Anything outside the 0x8xxx_xxxx window or off the map is REG_NONE.
    function automatic mmio_reg_e mmio_decode(input logic [31:0] addr);
        mmio_reg_e sel;
        sel = REG_NONE;
        if (addr[31:28] == 4'h8) begin
            case (addr)
                MMIO_UART_CTRL: sel = REG_UART_CTRL;
                MMIO_UART_RX:   sel = REG_UART_RX;
                MMIO_UART_TX:   sel = REG_UART_TX;
                MMIO_CYCLE_CNT: sel = REG_CYCLE_CNT;
                MMIO_INST_CNT:  sel = REG_INST_CNT;
                MMIO_CNT_RST:   sel = REG_CNT_RST;
                default:        sel = REG_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with combinational head output.
// A push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; depth is a power of two so
    // pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO controller between the CPU data port and the UART.
// Holds decode, RX/TX FIFOs, counters, overflow flag and load data.
module uart_mmio_ctrl
    import uart_mmio_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        inst_retired,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    mmio_reg_e   sel;
    logic        wr;
    logic [7:0]  rx_head;
    logic        rx_full;
    logic        rx_empty;
    logic        rx_push;
    logic        rx_pop;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_push;
    logic        tx_pop;
    logic        tx_overflow;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] rd_val;
    logic [31:0] status;

    assign sel      = mmio_decode(addr);
    assign wr       = |we;
    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = re && (sel == REG_UART_RX) && !rx_empty;
    assign tx_push  = wr && (sel == REG_UART_TX);
    assign tx_pop   = tx_valid && tx_ready;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Status word and load mux, both from pre-edge state.
    always_comb begin
        status = '0;
        status[ST_TX_NOT_FULL]  = !tx_full;
        status[ST_RX_NOT_EMPTY] = !rx_empty;
        status[ST_TX_OVERFLOW]  = tx_overflow;
        rd_val = '0;
        case (sel)
            REG_UART_CTRL: rd_val = status;
            REG_UART_RX:   rd_val = {24'b0, rx_head};
            REG_CYCLE_CNT: rd_val = cycle_cnt;
            REG_INST_CNT:  rd_val = inst_cnt;
            default:       rd_val = '0;
        endcase
    end

    // Sticky overflow: a TX push into a full FIFO with no same-cycle drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow <= 1'b0;
        end else if (wr && (sel == REG_UART_CTRL)) begin
            tx_overflow <= 1'b0;
        end else if (tx_push && tx_full && !tx_pop) begin
            tx_overflow <= 1'b1;
        end
    end

    // Cycle and retired-instruction counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || (wr && (sel == REG_CNT_RST))) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_retired) inst_cnt <= inst_cnt + 32'd1;
        end
    end

    // Registered load data, held until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Randomized bench for uart_mmio_ctrl against a queue-based model.
// Directed scenarios first, then random traffic, then counter wrap.
module tb_uart_mmio_ctrl;
    import uart_mmio_ctrl_pkg::*;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic [31:0] rdata;
    logic        inst_retired;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    uart_mmio_ctrl #(.FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wdata        (wdata),
        .we           (we),
        .re           (re),
        .rdata        (rdata),
        .inst_retired (inst_retired),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  m_rx[$];
    logic [7:0]  m_tx[$];
    logic        m_ovf;
    logic [31:0] m_cyc;
    logic [31:0] m_inst;
    logic [31:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        addr = '0; wdata = '0; we = '0; re = 1'b0;
        inst_retired = 1'b0; rx_valid = 1'b0; rx_data = '0;
        tx_ready = 1'b0; rst = 1'b0;
    endtask

    // One clock: model the edge from current inputs, then check outputs.
    task automatic step();
        logic        w;
        logic [31:0] rd;
        int          txn;
        int          rxn;
        bit          tpop;
        bit          tpush;
        bit          rpop;
        bit          rpush;
        w = |we;
        txn = m_tx.size();
        rxn = m_rx.size();
        if (rst) begin
            m_rx.delete(); m_tx.delete();
            m_ovf = 0; m_cyc = 0; m_inst = 0; m_rdata = 0;
        end else begin
            rd = 0;
            if (addr == MMIO_UART_CTRL)
                rd = {29'b0, m_ovf, rxn != 0, txn < D};
            else if (addr == MMIO_UART_RX)
                rd = (rxn > 0) ? {24'b0, m_rx[0]} : 32'h0;
            else if (addr == MMIO_CYCLE_CNT)
                rd = m_cyc;
            else if (addr == MMIO_INST_CNT)
                rd = m_inst;
            if (re) m_rdata = rd;
            tpop  = tx_ready && txn > 0;
            tpush = 0;
            if (w && addr == MMIO_UART_TX) begin
                if (txn < D || tpop) tpush = 1;
                else m_ovf = 1;
            end
            if (w && addr == MMIO_UART_CTRL) m_ovf = 0;
            rpop  = re && addr == MMIO_UART_RX && rxn > 0;
            rpush = rx_valid && rxn < D;
            if (tpop)  void'(m_tx.pop_front());
            if (tpush) m_tx.push_back(wdata[7:0]);
            if (rpop)  void'(m_rx.pop_front());
            if (rpush) m_rx.push_back(rx_data);
            if (w && addr == MMIO_CNT_RST) begin
                m_cyc = 0; m_inst = 0;
            end else begin
                m_cyc = m_cyc + 1;
                if (inst_retired) m_inst = m_inst + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("rdata", rdata, m_rdata);
        check("tx_valid", 32'(tx_valid), 32'(m_tx.size() != 0));
        check("tx_data", 32'(tx_data),
              (m_tx.size() != 0) ? 32'(m_tx[0]) : 32'h0);
        check("rx_ready", 32'(rx_ready), 32'(m_rx.size() < D));
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 4'hF;
        step();
        we = '0; addr = '0; wdata = '0;
    endtask

    task automatic rd_reg(input logic [31:0] a);
        addr = a; re = 1'b1;
        step();
        re = 1'b0; addr = '0;
    endtask

    int got_n;
    logic [7:0] last_b;
    logic [31:0] r;

    initial begin
        idle();
        m_ovf = 0; m_cyc = 0; m_inst = 0; m_rdata = 0;
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_rdata", rdata, 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h1);

        rd_reg(MMIO_UART_CTRL);
        check("status_reset", rdata, 32'h1);
        rd_reg(MMIO_UART_RX);
        check("rx_empty_read", rdata, 32'h0);
        rd_reg(MMIO_UART_CTRL);
        check("status_no_pop", rdata, 32'h1);

        wr_reg(MMIO_UART_TX, 32'h41);
        wr_reg(MMIO_UART_TX, 32'h42);
        wr_reg(MMIO_UART_TX, 32'h43);
        check("tx_head_41", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("tx_order", 32'(tx_data), 32'h41 + i);
            step();
        end
        check("tx_drained", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        for (int i = 0; i < 9; i++) wr_reg(MMIO_UART_TX, 32'h10 + i);
        rd_reg(MMIO_UART_CTRL);
        check("status_ovf", rdata, 32'h4);
        wr_reg(MMIO_UART_CTRL, 32'hDEAD_BEEF);
        rd_reg(MMIO_UART_CTRL);
        check("ovf_clear", rdata, 32'h0);
        got_n = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 12 && tx_valid; i++) begin
            last_b = tx_data;
            got_n++;
            step();
        end
        tx_ready = 1'b0;
        check("tx_kept_cnt", 32'(got_n), 32'd8);
        check("tx_9th_drop", 32'(last_b), 32'h17);

        rx_valid = 1'b1;
        for (int i = 0; i < D; i++) begin
            rx_data = 8'h61 + 8'(i);
            step();
        end
        rx_valid = 1'b0;
        check("rx_full", 32'(rx_ready), 32'h0);
        rd_reg(MMIO_UART_CTRL);
        check("status_rx", rdata & 32'h2, 32'h2);
        for (int i = 0; i < D; i++) begin
            rd_reg(MMIO_UART_RX);
            check("rx_byte", rdata, 32'h61 + i);
        end

        for (int i = 0; i < D; i++) wr_reg(MMIO_UART_TX, 32'h30 + i);
        tx_ready = 1'b1;
        wr_reg(MMIO_UART_TX, 32'h5A);
        tx_ready = 1'b0;
        rd_reg(MMIO_UART_CTRL);
        check("no_ovf_pp", rdata & 32'h4, 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 12 && tx_valid; i++) begin
            last_b = tx_data;
            step();
        end
        tx_ready = 1'b0;
        check("pp_last_5a", 32'(last_b), 32'h5A);

        wr_reg(MMIO_CNT_RST, 32'h0);
        for (int i = 0; i < 5; i++) begin
            inst_retired = 1'b1;
            step();
            inst_retired = 1'b0;
            step();
        end
        rd_reg(MMIO_INST_CNT);
        check("inst_5", rdata, 32'd5);
        inst_retired = 1'b1;
        wr_reg(MMIO_CNT_RST, 32'h0);
        inst_retired = 1'b0;
        rd_reg(MMIO_INST_CNT);
        check("inst_clr", rdata, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] amap [9];
            amap = '{MMIO_UART_CTRL, MMIO_UART_RX, MMIO_UART_TX,
                     MMIO_UART_TX, MMIO_CYCLE_CNT, MMIO_INST_CNT,
                     MMIO_CNT_RST, 32'h8000_000C, 32'h1000_0008};
            addr  = amap[$urandom_range(8, 0)];
            wdata = $urandom;
            we    = ($urandom_range(9, 0) < 3) ? 4'($urandom_range(15, 1)) : 4'h0;
            if (addr == MMIO_CNT_RST && $urandom_range(3, 0) != 0) we = 4'h0;
            re    = ($urandom_range(9, 0) < 4);
            rx_valid = $urandom_range(1, 0) == 1;
            rx_data  = 8'($urandom);
            tx_ready = ($urandom_range(9, 0) < 4);
            inst_retired = $urandom_range(1, 0) == 1;
            rst = ($urandom_range(999, 0) == 0);
            step();
        end
        idle();
        step();

        @(negedge clk);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        addr = MMIO_CYCLE_CNT;
        re = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("cyc_max", rdata, 32'hFFFF_FFFF);
        release dut.cycle_cnt;
        re = 1'b0;
        @(posedge clk);
        @(negedge clk);
        re = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("cyc_wrap", rdata, 32'h0);
        re = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
